// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Default geometry matches the RV32I architectural register set.
package regfile_pkg;

    typedef enum logic {
        INIT,
        READY
    } rf_state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_DEPTH = 32;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set beats clear.
// Lookup hides a busy bit whose producer is writing back in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          set_en,
    input  logic [AW-1:0]                 set_addr,
    input  logic [NUM_WR-1:0]             clr_en,
    input  logic [NUM_WR-1:0][AW-1:0]     clr_addr,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0]             rd_busy
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_next;
    logic [NUM_RD-1:0] wr_hit;
    logic [NUM_RD-1:0] set_hit;

    always_comb begin
        busy_next = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (clr_en[w]) begin
                busy_next[clr_addr[w]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // A same-cycle writeback retires the producer unless a new one issues now.
    always_comb begin
        wr_hit  = '0;
        set_hit = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (clr_en[w] && clr_addr[w] == rd_addr[p]) begin
                    wr_hit[p] = 1'b1;
                end
            end
            set_hit[p] = set_en && (set_addr == rd_addr[p]);
            rd_busy[p] = rd_en[p] && (rd_addr[p] != '0) && busy_q[rd_addr[p]]
                         && !(wr_hit[p] && !set_hit[p]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, a busy
// scoreboard and a hardware init sequencer that zeroes the array.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          ready,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_addr
);

    rf_state_e         state;
    rf_state_e         next_state;
    logic [AW-1:0]     init_cnt;
    logic [AW-1:0]     next_cnt;
    logic [XLEN-1:0]   regs [DEPTH];
    logic [NUM_WR-1:0] wr_act;
    logic [NUM_RD-1:0] rd_act;
    logic              iss_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= AW'(1);
        end else begin
            state    <= next_state;
            init_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = init_cnt;
        if (clr) begin
            next_state = INIT;
            next_cnt   = AW'(1);
        end else begin
            case (state)
                INIT: begin
                    next_cnt = init_cnt + AW'(1);
                    if (init_cnt == AW'(DEPTH - 1)) begin
                        next_state = READY;
                    end
                end
                READY: next_state = READY;
                default: next_state = INIT;
            endcase
        end
    end

    assign ready = (state == READY);

    // Writes to x0 and everything during INIT or a clear cycle are dropped.
    always_comb begin
        wr_act = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_act[w] = ready && !clr && wr_en[w] && (wr_addr[w] != '0);
        end
    end

    assign iss_act = ready && !clr && iss_en && (iss_addr != '0);
    assign rd_act  = ready ? rd_en : '0;

    // Later write ports are assigned last, so the highest index wins a conflict.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[init_cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w]) begin
                    regs[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w] && wr_addr[w] == rd_addr[p]) begin
                    rd_data[p] = wr_data[w];
                end
            end
            if (!rd_act[p] || rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .set_en   (iss_act),
        .set_addr (iss_addr),
        .clr_en   (wr_act),
        .clr_addr (wr_addr),
        .rd_en    (rd_act),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: init sequence, bypass, write
// priority, x0 handling, scoreboard set/clear and soft clear.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                        clk;
    logic                        rst;
    logic                        clr;
    logic                        ready;
    logic [NUM_RD-1:0]           rd_en;
    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR-1:0][AW-1:0]   wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0] wr_data;
    logic                        iss_en;
    logic [AW-1:0]               iss_addr;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ready    (ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic ien, input logic [4:0] ia);
        rd_en      = ren;
        rd_addr[0] = ra0;
        rd_addr[1] = ra1;
        wr_en      = wen;
        wr_addr[0] = wa0;
        wr_data[0] = wd0;
        wr_addr[1] = wa1;
        wr_data[1] = wd1;
        iss_en     = ien;
        iss_addr   = ia;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic readPair(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic b0, input logic b1);
        applyStimulus(2'b11, a0, a1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput({tag, "_d0"}, rd_data[0], d0);
        checkOutput({tag, "_d1"}, rd_data[1], d1);
        checkOutput({tag, "_b0"}, {31'b0, rd_busy[0]}, {31'b0, b0});
        checkOutput({tag, "_b1"}, {31'b0, rd_busy[1]}, {31'b0, b1});
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        applyStimulus(2'b11, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        stepClock();
        stepClock();
        checkOutput("rst_ready", {31'b0, ready}, 32'd0);
        checkOutput("rst_data0", rd_data[0], 32'h0);
        checkOutput("rst_busy0", {31'b0, rd_busy[0]}, 32'd0);
        rst = 1'b0;

        // Init: 31 cycles with ready low while a write/issue to x2 is attempted
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus(2'b11, 5'd2, AW'(i + 1), 2'b01, 5'd2, 32'hAAAA5555, 5'd0, 32'h0, 1'b1, 5'd2);
            checkOutput("init_ready", {31'b0, ready}, 32'd0);
            checkOutput("init_data0", rd_data[0], 32'h0);
            checkOutput("init_data1", rd_data[1], 32'h0);
            checkOutput("init_busy0", {31'b0, rd_busy[0]}, 32'd0);
            stepClock();
        end
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("init_done", {31'b0, ready}, 32'd1);
        readPair("init_x2", 5'd2, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0);

        // Same-cycle bypass of x5 then array read
        applyStimulus(2'b10, 5'd0, 5'd5, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("byp_x5", rd_data[1], 32'hDEADBEEF);
        checkOutput("byp_x5_en0", rd_data[0], 32'h0);
        stepClock();
        readPair("arr_x5", 5'd4, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Write conflict on x7: port 1 wins, bypass and array
        applyStimulus(2'b01, 5'd7, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
        checkOutput("conf_byp_x7", rd_data[0], 32'h22);
        stepClock();
        readPair("conf_arr_x7", 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 1'b0, 1'b0);

        // x0 is hardwired
        applyStimulus(2'b11, 5'd0, 5'd0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0);
        checkOutput("x0_byp", rd_data[0], 32'h0);
        checkOutput("x0_byp_busy", {31'b0, rd_busy[0]}, 32'd0);
        stepClock();
        readPair("x0_arr", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        stepClock();

        // Issue x9, wait, then write x9
        applyStimulus(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        checkOutput("iss_x9_same", {31'b0, rd_busy[0]}, 32'd0);
        stepClock();
        readPair("iss_x9_c1", 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1);
        stepClock();
        readPair("iss_x9_c2", 5'd9, 5'd7, 32'h0, 32'h22, 1'b1, 1'b0);
        applyStimulus(2'b11, 5'd9, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0);
        checkOutput("wb_x9_busy", {31'b0, rd_busy[0]}, 32'd0);
        checkOutput("wb_x9_data", rd_data[1], 32'h99);
        applyStimulus(2'b01, 5'd9, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0);
        checkOutput("x9_en_off_busy", {31'b0, rd_busy[1]}, 32'd0);
        checkOutput("x9_en_off_data", rd_data[1], 32'h0);
        stepClock();
        readPair("wb_x9_after", 5'd9, 5'd9, 32'h99, 32'h99, 1'b0, 1'b0);

        // Issue x3, then issue and write x3 together: set wins
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3);
        stepClock();
        applyStimulus(2'b01, 5'd3, 5'd0, 2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b1, 5'd3);
        checkOutput("setclr_x3_same", {31'b0, rd_busy[0]}, 32'd1);
        checkOutput("setclr_x3_data", rd_data[0], 32'h33);
        stepClock();
        readPair("setclr_x3_after", 5'd3, 5'd3, 32'h33, 32'h33, 1'b1, 1'b1);

        // Populate x1..x31, mark x12 busy, then soft clear
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(2'b00, 5'd0, 5'd0, 2'b01, AW'(i), 32'h0100_0000 + i, 5'd0, 32'h0, 1'b0, 5'd0);
            stepClock();
        end
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12);
        stepClock();
        readPair("pop_x12", 5'd12, 5'd31, 32'h0100_000C, 32'h0100_001F, 1'b1, 1'b0);
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b01, 5'd10, 32'hBAD0BAD0, 5'd0, 32'h0, 1'b1, 5'd11);
        clr = 1'b1;
        #1;
        stepClock();
        clr = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus(2'b11, 5'd12, AW'(i + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
            checkOutput("clr_ready", {31'b0, ready}, 32'd0);
            checkOutput("clr_data1", rd_data[1], 32'h0);
            checkOutput("clr_busy0", {31'b0, rd_busy[0]}, 32'd0);
            stepClock();
        end
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("clr_done", {31'b0, ready}, 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            readPair("clr_zero", AW'(i), AW'(DEPTH - i), 32'h0, 32'h0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
